// File: rtl/branch_predict_unit.sv
// Branch predict/resolve unit: a table of 2-bit saturating counters indexed
// by PC bits, plus an execute-stage branch comparator and a registered flush.
// Optional macro BPU_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred,
  input  logic            bolha,
  output logic            branch_taken,
  output logic            mispredict,
  output logic            flush_q
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [1:0] CTR_WNT    = 2'b01;
  localparam logic [1:0] CTR_SNT    = 2'b00;
  localparam logic [1:0] CTR_ST     = 2'b11;

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             flush_d;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic             is_br;
  logic             cond;

  // PC bits outside the index field carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  assign lk_idx     = if_pc[IDX_W+1:2];
  assign up_idx     = ex_pc[IDX_W+1:2];
  assign pred_taken = bht_q[lk_idx][1];

  // Resolve the branch condition and compare against the carried prediction.
  always_comb begin
    is_br = (ex_opcode == OPC_BRANCH) && !bolha;
    cond  = 1'b0;
    case (ex_funct3)
      3'b000:  cond = (ex_rs1 == ex_rs2);
      3'b001:  cond = (ex_rs1 != ex_rs2);
      3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond = (ex_rs1 <  ex_rs2);
      3'b111:  cond = (ex_rs1 >= ex_rs2);
      default: cond = 1'b0;
    endcase
    branch_taken = is_br && cond;
    mispredict   = is_br && (branch_taken ^ ex_pred);
    flush_d      = mispredict;
  end

  // Saturating update of the single counter addressed by the resolving PC.
  always_comb begin
    bht_d = bht_q;
    if (is_br) begin
      if (branch_taken) begin
        if (bht_q[up_idx] != CTR_ST) bht_d[up_idx] = bht_q[up_idx] + 2'd1;
      end else begin
        if (bht_q[up_idx] != CTR_SNT) bht_d[up_idx] = bht_q[up_idx] - 2'd1;
      end
    end
  end

  // Table and flush registers; reset re-seeds every counter to weak-not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_WNT;
      flush_q <= 1'b0;
    end else begin
      bht_q   <= bht_d;
      flush_q <= flush_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q,  stat_mispred_d;

  // Saturating event counters.
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (is_br && (stat_branches_q != 32'hFFFF_FFFF))
      stat_branches_d = stat_branches_q + 32'd1;
    if (mispredict && (stat_mispred_q != 32'hFFFF_FFFF))
      stat_mispred_d = stat_mispred_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= 32'd0;
      stat_mispred_q  <= 32'd0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: directed steps plus random traffic,
// checked against a counter-table reference model.
module tb_branch_predict_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned N    = 16;

  logic            clk, rst;
  logic [XLEN-1:0] if_pc, ex_pc, ex_rs1, ex_rs2;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            ex_pred, bolha;
  logic            pred_taken, branch_taken, mispredict, flush_q;
`ifdef BPU_STATS_EN
  logic [31:0]     stat_branches, stat_mispred;
`endif

  branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred(ex_pred), .bolha(bolha),
    .branch_taken(branch_taken), .mispredict(mispredict), .flush_q(flush_q)
`ifdef BPU_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ctr [N];
  bit          m_flush;
  int unsigned m_nbr, m_nmis;

  function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) <  int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational and registered outputs, clock, update model.
  task automatic step(input logic [6:0] opc, input logic [2:0] f3,
                      input logic [31:0] epc, input logic [31:0] a,
                      input logic [31:0] b, input bit ep, input bit bub,
                      input logic [31:0] ipc, input bit r);
    bit is_br, tk, mis;
    int ui;
    ex_opcode = opc; ex_funct3 = f3; ex_pc = epc; ex_rs1 = a; ex_rs2 = b;
    ex_pred = ep; bolha = bub; if_pc = ipc; rst = r;
    is_br = (opc == 7'h63) && !bub;
    tk    = is_br && m_cond(f3, a, b);
    mis   = is_br && (tk != ep);
    #4;
    chk("branch_taken", branch_taken, tk);
    chk("mispredict", mispredict, mis);
    chk("pred_taken", pred_taken, m_ctr[(ipc >> 2) % N] >= 2);
    chk("flush_q", flush_q, m_flush);
`ifdef BPU_STATS_EN
    chk32("stat_branches", stat_branches, m_nbr);
    chk32("stat_mispred", stat_mispred, m_nmis);
`endif
    @(posedge clk);
    if (r) begin
      foreach (m_ctr[i]) m_ctr[i] = 1;
      m_flush = 1'b0; m_nbr = 0; m_nmis = 0;
    end else begin
      ui = int'((epc >> 2) % N);
      if (is_br) m_ctr[ui] = tk ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                                : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
      m_flush = mis;
      if (is_br && m_nbr != 32'hFFFF_FFFF) m_nbr++;
      if (mis && m_nmis != 32'hFFFF_FFFF) m_nmis++;
    end
    #1;
  endtask

  localparam logic [6:0] BR = 7'h63;
  localparam logic [6:0] NB = 7'h13;

  initial begin
    logic [6:0]  opc;
    logic [31:0] a, b;
    // Initial reset
    ex_opcode = NB; ex_funct3 = 3'd0; ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_pred = 1'b0; bolha = 1'b0; if_pc = '0; rst = 1'b1;
    @(posedge clk); #1;
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_flush = 1'b0; m_nbr = 0; m_nmis = 0;

    // All entries predict not-taken after reset
    step(NB, 3'd0, 32'h0, 0, 0, 0, 0, 32'h100, 0);
    for (int i = 0; i < N; i++) step(NB, 3'd0, 32'h0, 0, 0, 0, 0, 32'(i * 4), 0);

    // BEQ at 0x40, equal operands, predicted not-taken: lookup same index
    step(BR, 3'd0, 32'h40, 5, 5, 0, 0, 32'h40, 0);
    step(BR, 3'd0, 32'h40, 5, 5, 0, 0, 32'h40, 0);
    step(NB, 3'd0, 32'h0, 0, 0, 0, 0, 32'h40, 0);

    // Signed vs unsigned less-than on 0xFFFFFFFF vs 1
    step(BR, 3'd4, 32'h44, 32'hFFFF_FFFF, 1, 1, 0, 32'h44, 0);
    step(BR, 3'd6, 32'h48, 32'hFFFF_FFFF, 1, 0, 0, 32'h48, 0);
    step(BR, 3'd5, 32'h48, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 32'h48, 0);
    step(BR, 3'd7, 32'h48, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 32'h48, 0);

    // Five taken then one not-taken at 0x80, then two more not-taken
    for (int i = 0; i < 5; i++) step(BR, 3'd1, 32'h80, 1, 2, 1, 0, 32'h80, 0);
    step(BR, 3'd1, 32'h80, 3, 3, 1, 0, 32'h80, 0);
    step(BR, 3'd1, 32'h80, 3, 3, 1, 0, 32'h80, 0);
    step(BR, 3'd1, 32'h80, 3, 3, 0, 0, 32'h80, 0);
    step(NB, 3'd0, 32'h0, 0, 0, 0, 0, 32'h80, 0);

    // Bubble: no resolution, no update
    step(BR, 3'd1, 32'h40, 1, 2, 0, 1, 32'h40, 0);
    step(NB, 3'd0, 32'h0, 0, 0, 0, 0, 32'h40, 0);

    // Invalid funct3 counts as not-taken and decrements
    step(BR, 3'd2, 32'h40, 7, 7, 1, 0, 32'h40, 0);
    step(BR, 3'd3, 32'h40, 7, 7, 0, 0, 32'h40, 0);
    step(NB, 3'd0, 32'h0, 0, 0, 0, 0, 32'h40, 0);

    // Back-to-back mispredicts, then reset discards the pending flush
    step(BR, 3'd0, 32'h10, 1, 1, 0, 0, 32'h10, 0);
    step(BR, 3'd0, 32'h14, 1, 2, 1, 0, 32'h10, 0);
    step(BR, 3'd0, 32'h10, 1, 1, 0, 0, 32'h10, 1);
    step(NB, 3'd0, 32'h0, 0, 0, 0, 0, 32'h10, 0);

    // Random traffic with occasional bubbles and resets
    for (int n = 0; n < 400; n++) begin
      opc = ($urandom_range(0, 7) != 0) ? BR : 7'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 ^ $urandom_range(0, 3) : $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      step(opc, 3'($urandom), 32'($urandom_range(0, 255)), a, b,
           1'($urandom), ($urandom_range(0, 7) == 0),
           32'($urandom_range(0, 255)), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
